// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues single-outstanding
// word reads to instruction memory and buffers up to two {instruction, PC+4}
// pairs for the IF/ID register. A redirect flushes the buffer and squashes any
// read still in flight. Empty head slots are presented as all-zero bubbles.
// Optional feature macro: FETCH_PERF_CNT_EN adds the bubble_cnt output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ins_out,
  output logic [31:0] pc4_out,
  output logic        ins_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  // Architectural fetch state
  logic [31:0] pc;
  logic [31:0] pend_pc4;
  logic        outstanding;
  logic        kill;

  // Two-entry buffer: circular storage addressed by head and occupancy
  logic [31:0] ins_q [2];
  logic [31:0] pc4_q [2];
  logic        head;
  logic [1:0]  count;

  // Per-cycle control decisions
  logic        issue;
  logic        fire;
  logic        push;
  logic        pop;
  logic        tail;

  // Issue only when nothing is in flight and the buffer has room for the reply
  always_comb begin
    issue = 1'b0;
    fire  = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    tail  = head ^ count[0];
    if (!reset && !redirect && !outstanding && (count != 2'd2)) begin
      issue = 1'b1;
    end
    fire = issue && imem_gnt;
    push = imem_rvalid && outstanding && !kill && !redirect;
    pop  = !stall && (count != 2'd0);
  end

  assign imem_req  = issue;
  assign imem_addr = reset ? RESET_PC : pc;

  // PC, in-flight tracking and squash flag; redirect overrides everything else
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_pc4    <= RESET_PC + 32'd4;
      outstanding <= 1'b0;
      kill        <= 1'b0;
    end else if (redirect) begin
      pc <= redirect_pc & 32'hFFFF_FFFC;
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        kill        <= 1'b0;
      end else if (outstanding) begin
        kill <= 1'b1;
      end
    end else begin
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        kill        <= 1'b0;
      end
      if (fire) begin
        outstanding <= 1'b1;
        pc          <= pc + 32'd4;
        pend_pc4    <= pc + 32'd4;
      end
    end
  end

  // Buffer occupancy and head pointer; a flush simply empties the buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      head  <= 1'b0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        head <= ~head;
      end
    end
  end

  // Buffer data storage; entries are only meaningful while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[tail] <= imem_rdata;
      pc4_q[tail] <= pend_pc4;
    end
  end

  // Present the registered head, or a zero bubble when the buffer is empty
  always_comb begin
    ins_valid = (count != 2'd0);
    ins_out   = 32'h0;
    pc4_out   = 32'h0;
    if (ins_valid) begin
      ins_out = ins_q[head];
      pc4_out = pc4_q[head];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count every edge where decode wanted an instruction but got a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= 32'h0;
    end else if (!stall && !ins_valid) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

  // Memory must never answer without a request in flight
  assert property (@(posedge clk) disable iff (reset) imem_rvalid |-> outstanding);

  // Buffer occupancy never exceeds its two entries
  assert property (@(posedge clk) disable iff (reset) count <= 2'd2);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a behavioural
// instruction memory (configurable grant wait and read latency) that returns
// each word's own address as its data.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc4;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins_out;
  logic [31:0] pc4_out;
  logic        ins_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  // Memory model and scoreboard state
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        stale;
  int          lat;
  int          gnt_wait;
  logic [31:0] exp_pc;
  logic [31:0] exp_bub;
  logic        last_fire;
  entry_t      exp_q[$];
  int          checks;
  int          failures;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ins_out    (ins_out),
    .pc4_out    (pc4_out),
    .ins_valid  (ins_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a loop bound is ever missed
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, play memory, update the model, check outputs
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
    logic        fire;
    logic        resp;
    logic        iv_pre;
    logic        keep;
    logic [31:0] resp_addr;
    logic [31:0] fire_addr;
    entry_t      e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_addr : $urandom;
    #1;
    imem_gnt = imem_req && (gnt_wait == 0);
    #1;
    if (reset) begin
      checkOutput("reset_req", {31'b0, imem_req}, 32'd0);
      checkOutput("reset_addr", imem_addr, RPC);
    end else begin
      if (rd) checkOutput("req_redirect", {31'b0, imem_req}, 32'd0);
      else if (mem_busy || exp_q.size() == 2) checkOutput("req_blocked", {31'b0, imem_req}, 32'd0);
      else checkOutput("req_issue", {31'b0, imem_req}, 32'd1);
      if (imem_req) checkOutput("req_addr", imem_addr, exp_pc);
    end
    fire      = imem_req && imem_gnt;
    resp      = imem_rvalid;
    resp_addr = mem_addr;
    fire_addr = imem_addr;
    iv_pre    = ins_valid;
    if (imem_req && !imem_gnt && gnt_wait > 0) gnt_wait--;
    last_fire = fire;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      mem_busy = 1'b0;
      stale    = 1'b0;
      exp_pc   = RPC;
      exp_bub  = 32'd0;
    end else begin
      if (!st && !iv_pre) exp_bub = exp_bub + 32'd1;
      keep = 1'b0;
      if (resp) begin
        mem_busy = 1'b0;
        keep     = !stale && !rd;
        stale    = 1'b0;
      end else if (mem_busy) begin
        mem_cnt--;
      end
      if (fire) begin
        mem_busy = 1'b1;
        mem_cnt  = lat - 1;
        mem_addr = fire_addr;
        exp_pc   = exp_pc + 32'd4;
      end
      if (rd) begin
        exp_q.delete();
        if (mem_busy) stale = 1'b1;
        exp_pc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (!st && exp_q.size() > 0) void'(exp_q.pop_front());
        if (keep) begin
          e.ins = resp_addr;
          e.pc4 = resp_addr + 32'd4;
          exp_q.push_back(e);
        end
      end
    end
    #1;
    if (exp_q.size() > 0) begin
      checkOutput("valid", {31'b0, ins_valid}, 32'd1);
      checkOutput("ins_out", ins_out, exp_q[0].ins);
      checkOutput("pc4_out", pc4_out, exp_q[0].pc4);
    end else begin
      checkOutput("valid", {31'b0, ins_valid}, 32'd0);
      checkOutput("ins_out_zero", ins_out, 32'd0);
      checkOutput("pc4_out_zero", pc4_out, 32'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("bubble_cnt", bubble_cnt, exp_bub);
`endif
    @(negedge clk);
  endtask

  // Directed scenarios followed by a randomised soak
  initial begin
    int valid_seen;
    bit done;
    checks = 0; failures = 0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'd0; stale = 1'b0;
    lat = 1; gnt_wait = 0; exp_pc = RPC; exp_bub = 32'd0; last_fire = 1'b0;
    @(negedge clk);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
    reset = 1'b0;

    // Zero-wait memory: one instruction every two cycles
    valid_seen = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      valid_seen += int'(ins_valid);
      if (i == 1) begin
        checkOutput("first_ins", ins_out, 32'h100);
        checkOutput("first_pc4", pc4_out, 32'h104);
      end
      if (i == 3) begin
        checkOutput("second_ins", ins_out, 32'h104);
        checkOutput("second_pc4", pc4_out, 32'h108);
      end
    end
    checkOutput("valid_rate", valid_seen, 32'd6);

    // Hold decode off until the buffer fills, then drain
    repeat (6) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("full_valid", {31'b0, ins_valid}, 32'd1);
    checkOutput("full_no_req", {31'b0, imem_req}, 32'd0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);

    // Slow memory, redirect one cycle after grant squashes the stale read
    lat = 3;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      done = last_fire;
    end
    checkOutput("slow_grant_seen", {31'b0, done}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h2000);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      done = ins_valid;
    end
    checkOutput("redir_arrived", {31'b0, done}, 32'd1);
    checkOutput("redir_ins", ins_out, 32'h2000);
    checkOutput("redir_pc4", pc4_out, 32'h2004);

    // Redirect while stalled with a full buffer, unaligned target
    lat = 1;
    repeat (6) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("pre_flush_valid", {31'b0, ins_valid}, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h2003);
    checkOutput("flush_valid", {31'b0, ins_valid}, 32'd0);
    checkOutput("flush_addr", imem_addr, 32'h2000);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      done = ins_valid;
    end
    checkOutput("wrap_ins", ins_out, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", pc4_out, 32'h0000_0000);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);

    // Delayed grant: request must be held until accepted
    gnt_wait = 3;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'd0);

    // Reset while a slow read is in flight
    lat = 3;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      done = last_fire;
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    repeat (8) applyStimulus(1'b0, 1'b0, 32'd0);

    // Random soak over stalls, redirects, latencies and grant waits
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(1, 4));
      if ($urandom_range(0, 15) == 0) gnt_wait = int'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined CPU: owns the PC, issues word reads to instruction memory, and produces the instruction / PC+4 pair consumed by the IF/ID stage register. A 2-entry output buffer absorbs decode stalls and variable memory latency. A redirect from branch/jump resolution flushes the buffer and squashes in-flight fetches. Empty slots are presented as NOP bubbles (all zeros).

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request, level; held until imem_gnt or redirect
- imem_addr  out  32  word address of request; bits [1:0] always 00
- imem_gnt  in  1  memory accepts request this cycle when imem_req=1
- imem_rvalid  in  1  read data valid; one response per grant, in order, earliest the cycle after gnt
- imem_rdata  in  32  instruction word
- stall  in  1  decode not consuming this cycle; buffer head held
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 00)
- ins_out  out  32  buffer head instruction; 0 when ins_valid=0
- pc4_out  out  32  buffer head address+4; 0 when ins_valid=0
- ins_valid  out  1  buffer head holds a real instruction
- bubble_cnt  out  32  only with FETCH_PERF_CNT_EN (see Configuration)

## Operation
- State: pc (next fetch address), 2-entry FIFO {ins, pc4}, count 0..2, outstanding flag (at most 1 request in flight), kill flag.
- Issue: imem_req=1, imem_addr=pc when !reset, !redirect, outstanding=0 and count<2 (count includes nothing in flight, so a response always has a slot). On req&&gnt: outstanding<=1, pc<=pc+4 (mod 2^32).
- Response: on imem_rvalid: outstanding<=0; if kill: drop data, kill<=0; else push {imem_rdata, addr+4}.
- Consume: on rising edge with stall=0 and count>0, pop head. Push and pop in same cycle allowed (count unchanged; at count=2 pop frees head, push goes to tail).
- Redirect (priority over stall, push, pop, issue): count<=0; pc<=redirect_pc&~3; imem_req=0 that cycle; if outstanding=1 or (req&&gnt same cycle) then kill<=1 and outstanding stays/becomes 1. Response arriving in the redirect cycle itself is dropped and clears that outstanding.
- Outputs are the registered FIFO head; no combinational path from imem_rdata to ins_out.

## Timing
- Reset: pc=RESET_PC, count=0, outstanding=0, kill=0; ins_out=0, pc4_out=0, ins_valid=0, imem_req=0, imem_addr=RESET_PC, bubble_cnt=0. Reset mid-transaction abandons any in-flight response: memory is reset together with this block.
- First imem_req in the first cycle after reset deasserts.
- Latency: gnt cycle N, rvalid cycle M>N, instruction on ins_out at cycle M+1.
- Zero-wait memory (gnt same cycle as req, rvalid next cycle): one instruction every 2 cycles (single outstanding request).
- Redirect at cycle R: ins_valid=0 at R+1; new request issued at R+1 (if no outstanding) else the cycle after the killed response returns.
- FIFO full with stall=1: imem_req stays 0; no data lost.

## Configuration
- FETCH_PERF_CNT_EN defined: port bubble_cnt present; increments (wrapping at 2^32) on every edge where stall=0 and ins_valid=0 and reset=0; cleared by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory returning addr as data -> imem_addr 0x100, 0x104, 0x108 on successive requests; ins_out/pc4_out 0x100/0x104 then 0x104/0x108, ins_valid pulsing every 2 cycles.
- stall=1 held 6 cycles -> count reaches 2, imem_req drops, ins_out frozen; release -> both buffered words emitted in order, no loss or duplicate.
- Memory with 3-cycle latency, redirect to 0x2000 one cycle after gnt -> stale response dropped, ins_valid=0 until data for 0x2000 arrives, pc4_out=0x2004.
- redirect and stall=1 same cycle with count=2 -> buffer flushed (ins_valid=0 next cycle), next fetch at redirect_pc; redirect_pc=0x2003 fetches 0x2000.
- Wrap: redirect_pc=0xFFFFFFFC -> pc4_out=0x00000000, next imem_addr=0x00000000.
- With FETCH_PERF_CNT_EN: 10 cycles of stall=0 after reset with 2-cycle-per-instruction memory -> bubble_cnt equals number of ins_valid=0 cycles observed (exact count checked against scoreboard).
